// File: rtl/prim_ram_2p_scrub_ctrl.sv
// Port-A initiator for the ECC-protected 2-port RAM wrapper: zero-init, periodic
// scrub reads, write-back of corrected words, and saturating error counters.
module prim_ram_2p_scrub_ctrl #(
    parameter int Depth  = 512,
    parameter int Width  = 32,
    parameter int SramAw = (Depth > 1) ? $clog2(Depth) : 1,
    parameter int IntW   = 16,
    parameter int CntW   = 8
) (
    input  logic              clk_a_i,
    input  logic              rst_ni,
    input  logic              init_req_i,
    input  logic              scrub_en_i,
    input  logic [IntW-1:0]   scrub_int_i,
    input  logic              clr_cnt_i,
    output logic              req_o,
    output logic              write_o,
    output logic [SramAw-1:0] addr_o,
    output logic [Width-1:0]  wdata_o,
    input  logic              rvalid_i,
    input  logic [Width-1:0]  rdata_i,
    input  logic [1:0]        rerror_i,
    output logic              init_done_o,
    output logic              busy_o,
    output logic [CntW-1:0]   corr_cnt_o,
    output logic [CntW-1:0]   uncorr_cnt_o
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_INIT,
        ST_RD,
        ST_RWAIT,
        ST_WB
    } state_e;

    localparam logic [SramAw-1:0] LastAddr = SramAw'(Depth - 1);
    localparam logic [CntW-1:0]   CntMax   = '1;

    state_e              r_state;
    logic                r_init_pend;
    logic                r_init_done;
    logic [SramAw-1:0]   r_scrub_addr;
    logic [IntW-1:0]     r_timer;
    logic                r_req;
    logic                r_write;
    logic [SramAw-1:0]   r_addr;
    logic [Width-1:0]    r_wdata;
    logic [CntW-1:0]     r_corr_cnt;
    logic [CntW-1:0]     r_uncorr_cnt;

    logic                w_last_init;
    logic [SramAw-1:0]   w_next_scrub;
    logic                w_corr_hit;
    logic                w_uncorr_hit;

    assign w_last_init  = (r_addr == LastAddr);
    assign w_next_scrub = (r_scrub_addr == LastAddr) ? '0 : r_scrub_addr + SramAw'(1);
    // Uncorrectable wins when both status bits are set.
    assign w_uncorr_hit = (r_state == ST_RWAIT) && rvalid_i && rerror_i[1];
    assign w_corr_hit   = (r_state == ST_RWAIT) && rvalid_i && !rerror_i[1] && rerror_i[0];

    always_ff @(posedge clk_a_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state      <= ST_IDLE;
            r_init_pend  <= 1'b0;
            r_init_done  <= 1'b0;
            r_scrub_addr <= '0;
            r_timer      <= '0;
            r_req        <= 1'b0;
            r_write      <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= '0;
        end else begin
            r_req   <= 1'b0;
            r_write <= 1'b0;
            if (r_state == ST_IDLE && r_timer != '0) begin
                r_timer <= r_timer - IntW'(1);
            end
            // A request seen during INIT is dropped rather than queued for a rerun.
            if (init_req_i && r_state != ST_INIT) begin
                r_init_pend <= 1'b1;
            end
            case (r_state)
                ST_IDLE: begin
                    if (r_init_pend) begin
                        r_state     <= ST_INIT;
                        r_req       <= 1'b1;
                        r_write     <= 1'b1;
                        r_addr      <= '0;
                        r_wdata     <= '0;
                        r_init_done <= 1'b0;
                    end else if (scrub_en_i && r_timer == '0) begin
                        r_state <= ST_RD;
                        r_req   <= 1'b1;
                        r_addr  <= r_scrub_addr;
                    end
                end
                ST_INIT: begin
                    if (w_last_init) begin
                        r_state      <= ST_IDLE;
                        r_init_done  <= 1'b1;
                        r_init_pend  <= 1'b0;
                        r_scrub_addr <= '0;
                    end else begin
                        r_req   <= 1'b1;
                        r_write <= 1'b1;
                        r_addr  <= r_addr + SramAw'(1);
                    end
                end
                ST_RD: begin
                    r_state <= ST_RWAIT;
                end
                ST_RWAIT: begin
                    if (w_corr_hit) begin
                        r_state <= ST_WB;
                        r_req   <= 1'b1;
                        r_write <= 1'b1;
                        r_addr  <= r_scrub_addr;
                        r_wdata <= rdata_i;
                    end else if (rvalid_i) begin
                        r_state      <= ST_IDLE;
                        r_scrub_addr <= w_next_scrub;
                        r_timer      <= scrub_int_i;
                    end
                end
                ST_WB: begin
                    r_state      <= ST_IDLE;
                    r_scrub_addr <= w_next_scrub;
                    r_timer      <= scrub_int_i;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk_a_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_corr_cnt   <= '0;
            r_uncorr_cnt <= '0;
        end else if (clr_cnt_i) begin
            r_corr_cnt   <= '0;
            r_uncorr_cnt <= '0;
        end else begin
            if (w_corr_hit && r_corr_cnt != CntMax) begin
                r_corr_cnt <= r_corr_cnt + CntW'(1);
            end
            if (w_uncorr_hit && r_uncorr_cnt != CntMax) begin
                r_uncorr_cnt <= r_uncorr_cnt + CntW'(1);
            end
        end
    end

    assign req_o        = r_req;
    assign write_o      = r_write;
    assign addr_o       = r_addr;
    assign wdata_o      = r_wdata;
    assign init_done_o  = r_init_done;
    assign busy_o       = (r_state != ST_IDLE);
    assign corr_cnt_o   = r_corr_cnt;
    assign uncorr_cnt_o = r_uncorr_cnt;

endmodule
